// File: rtl/axi_llc_pkg.sv
// rtl/axi_llc_pkg.sv - shared LLC configuration, payload types and refill FSM states
// Contents: llc_cfg_t / llc_axi_cfg_t configuration records and their defaults,
//           descriptor, AXI R payload and data-way write request types,
//           AxReqId (ID the LLC uses for its own memory requests),
//           refill_state_e for the refill R slave.
package axi_llc_pkg;

    localparam int unsigned MstIdWidth  = 4;
    localparam int unsigned AddrWidth   = 32;
    localparam int unsigned DataWidth   = 64;
    localparam int unsigned IndexWidth  = 8;
    localparam int unsigned BlkOfsWidth = 2;
    localparam int unsigned WayWidth    = 8;

    typedef struct packed {
        int unsigned NumBlocks;
        int unsigned BlockSize;
        int unsigned IndexLength;
        int unsigned ByteOffsetLength;
        int unsigned BlockOffsetLength;
    } llc_cfg_t;

    typedef struct packed {
        int unsigned SlvPortIdWidth;
        int unsigned AddrWidthFull;
        int unsigned DataWidthFull;
    } llc_axi_cfg_t;

    localparam llc_cfg_t DefaultCfg = '{
        NumBlocks:         4,
        BlockSize:         64,
        IndexLength:       IndexWidth,
        ByteOffsetLength:  3,
        BlockOffsetLength: BlkOfsWidth
    };

    localparam llc_axi_cfg_t DefaultAxiCfg = '{
        SlvPortIdWidth: MstIdWidth - 1,
        AddrWidthFull:  AddrWidth,
        DataWidthFull:  DataWidth
    };

    // The master port has one more ID bit than the slave port; setting the
    // extra MSB keeps LLC-internal refills apart from forwarded requests.
    localparam logic [MstIdWidth-1:0] AxReqId = 4'b1000;

    // refill: 1 -> the block is missing and must be fetched before the
    // descriptor may continue; 0 -> pass the descriptor straight on.
    typedef struct packed {
        logic [AddrWidth-1:0] a_x_addr;
        logic [WayWidth-1:0]  way_ind;
        logic                 refill;
    } llc_desc_t;

    typedef struct packed {
        logic [MstIdWidth-1:0] id;
        logic [DataWidth-1:0]  data;
        logic [1:0]            resp;
        logic                  last;
    } llc_r_chan_t;

    typedef struct packed {
        logic [IndexWidth-1:0]  index;
        logic [WayWidth-1:0]    way_ind;
        logic [BlkOfsWidth-1:0] blk_ofs;
        logic [DataWidth-1:0]   data;
    } llc_way_wr_t;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        SEND
    } refill_state_e;

endpackage

// File: rtl/axi_llc_refill_r_slave.sv
// rtl/axi_llc_refill_r_slave.sv - LLC refill R-channel slave: writes memory read beats into the data ways
// Build option: define AXI_LLC_R_PROTOCOL_CHECK_EN to check rid/rlast and pulse proto_err_o.
// Ports: clk_i, rst_i (async, active-high)
//        desc_i/desc_valid_i/desc_ready_o        descriptor in from the refill AR stage
//        desc_o/desc_valid_o/desc_ready_i        descriptor out to the next unit
//        r_chan_i/r_valid_i/r_ready_o            AXI R channel from memory
//        way_wr_o/way_wr_valid_o/way_wr_ready_i  block write into the data ways
//        resp_err_o                              pulse on an R beat with SLVERR/DECERR
//        proto_err_o                             pulse on an R protocol violation
module axi_llc_refill_r_slave
    import axi_llc_pkg::*;
#(
    parameter llc_cfg_t     Cfg      = DefaultCfg,
    parameter llc_axi_cfg_t AxiCfg   = DefaultAxiCfg,
    parameter type          desc_t   = llc_desc_t,
    parameter type          r_chan_t = llc_r_chan_t,
    parameter type          way_wr_t = llc_way_wr_t
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  desc_t   desc_i,
    input  logic    desc_valid_i,
    output logic    desc_ready_o,
    output desc_t   desc_o,
    output logic    desc_valid_o,
    input  logic    desc_ready_i,
    input  r_chan_t r_chan_i,
    input  logic    r_valid_i,
    output logic    r_ready_o,
    output way_wr_t way_wr_o,
    output logic    way_wr_valid_o,
    input  logic    way_wr_ready_i,
    output logic    resp_err_o,
    output logic    proto_err_o
);

    localparam int unsigned AddrOffset = Cfg.ByteOffsetLength + Cfg.BlockOffsetLength;
    localparam int unsigned CntWidth   = (Cfg.NumBlocks > 1) ? $clog2(Cfg.NumBlocks) : 1;
    localparam logic [CntWidth-1:0] LastBeat = CntWidth'(Cfg.NumBlocks - 1);

    refill_state_e                state_q, state_d;
    desc_t                        desc_q, desc_d;
    logic [CntWidth-1:0]          beat_cnt_q, beat_cnt_d;
    logic                         r_hs;
    logic                         last_beat;
    logic [AxiCfg.SlvPortIdWidth:0] rid;
    logic                         unused_r;

    assign r_hs      = (state_q == REFILL) && r_valid_i && way_wr_ready_i;
    assign last_beat = (beat_cnt_q == LastBeat);
    assign rid       = r_chan_i.id;
    assign unused_r  = ^{r_chan_i.resp[0], rid, r_chan_i.last};

    assign desc_o     = desc_q;
    assign resp_err_o = r_hs && r_chan_i.resp[1];

`ifdef AXI_LLC_R_PROTOCOL_CHECK_EN
    assign proto_err_o = r_hs && ((r_chan_i.last != last_beat) || (rid != AxReqId));
`else
    assign proto_err_o = 1'b0;
`endif

    // The burst length is fixed by the block size, so the beat counter alone
    // ends the refill; rlast is only looked at by the optional checker.
    always_comb begin
        state_d        = state_q;
        desc_d         = desc_q;
        beat_cnt_d     = beat_cnt_q;
        desc_ready_o   = 1'b0;
        desc_valid_o   = 1'b0;
        r_ready_o      = 1'b0;
        way_wr_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                desc_ready_o = 1'b1;
                if (desc_valid_i) begin
                    desc_d     = desc_i;
                    beat_cnt_d = '0;
                    state_d    = desc_i.refill ? REFILL : SEND;
                end
            end
            REFILL: begin
                way_wr_valid_o = r_valid_i;
                r_ready_o      = way_wr_ready_i;
                if (r_hs) begin
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = SEND;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            SEND: begin
                desc_valid_o = 1'b1;
                if (desc_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        way_wr_o         = '0;
        way_wr_o.index   = desc_q.a_x_addr[AddrOffset +: Cfg.IndexLength];
        way_wr_o.way_ind = desc_q.way_ind;
        way_wr_o.blk_ofs = beat_cnt_q;
        way_wr_o.data    = r_chan_i.data;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            desc_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            desc_q     <= desc_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_llc_refill_r_slave.sv
// tb/tb_axi_llc_refill_r_slave.sv - directed table-driven bench for axi_llc_refill_r_slave
module tb_axi_llc_refill_r_slave;
    import axi_llc_pkg::*;

`ifdef AXI_LLC_R_PROTOCOL_CHECK_EN
    localparam bit ProtoEn = 1'b1;
`else
    localparam bit ProtoEn = 1'b0;
`endif

    localparam logic [31:0] Addr = 32'h0000_0240;
    localparam logic [7:0]  Way  = 8'h04;
    localparam logic [7:0]  Idx  = 8'h12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    llc_desc_t   desc_in, desc_out;
    logic        desc_valid_in, desc_ready_out, desc_valid_out, desc_ready_in;
    llc_r_chan_t r_in;
    logic        r_valid, r_ready;
    llc_way_wr_t wr;
    logic        wr_valid, wr_ready;
    logic        resp_err, proto_err;
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    axi_llc_refill_r_slave #(
        .Cfg    (DefaultCfg),
        .AxiCfg (DefaultAxiCfg)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .desc_i         (desc_in),
        .desc_valid_i   (desc_valid_in),
        .desc_ready_o   (desc_ready_out),
        .desc_o         (desc_out),
        .desc_valid_o   (desc_valid_out),
        .desc_ready_i   (desc_ready_in),
        .r_chan_i       (r_in),
        .r_valid_i      (r_valid),
        .r_ready_o      (r_ready),
        .way_wr_o       (wr),
        .way_wr_valid_o (wr_valid),
        .way_wr_ready_i (wr_ready),
        .resp_err_o     (resp_err),
        .proto_err_o    (proto_err)
    );

    typedef struct {
        bit          dv, refill, rv;
        logic [63:0] data;
        logic [1:0]  resp;
        bit          last, wwr, dri;
        bit          e_dr, e_dv, e_rr, e_wv;
        logic [1:0]  e_ofs;
        bit          e_re, e_pe;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit dv, bit refill, bit rv, logic [63:0] data, logic [1:0] resp,
                                bit last, bit wwr, bit dri, bit e_dr, bit e_dv, bit e_rr,
                                bit e_wv, logic [1:0] e_ofs, bit e_re, bit e_pe);
        vec_t v;
        v.dv = dv; v.refill = refill; v.rv = rv; v.data = data; v.resp = resp;
        v.last = last; v.wwr = wwr; v.dri = dri;
        v.e_dr = e_dr; v.e_dv = e_dv; v.e_rr = e_rr; v.e_wv = e_wv;
        v.e_ofs = e_ofs; v.e_re = e_re; v.e_pe = e_pe;
        return v;
    endfunction

    function automatic vec_t acc(bit refill, bit rv);
        return mk(1, refill, rv, 64'h0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 2'd0, 0, 0);
    endfunction

    function automatic vec_t bt(logic [63:0] d, logic [1:0] ofs, logic [1:0] resp, bit last,
                                bit wwr, bit e_pe);
        return mk(0, 0, 1, d, resp, last, wwr, 0, 0, 0, wwr, 1, ofs, resp[1] & wwr, e_pe);
    endfunction

    function automatic vec_t snd(bit dri, bit rv);
        return mk(0, 0, rv, 64'h0, 2'b00, 0, 1, dri, 0, 1, 0, 0, 2'd0, 0, 0);
    endfunction

    function automatic vec_t idl(bit rv);
        return mk(0, 0, rv, 64'h0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 2'd0, 0, 0);
    endfunction

    function automatic logic [63:0] dat(int s, int k);
        return 64'hC0FF_EE00_0000_0000 | 64'(s * 256 + k);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Called at posedge+1: drive, sample at the falling edge, advance one clock.
    task automatic run_vec(input vec_t t, input string nm);
        desc_valid_in    = t.dv;
        desc_in          = '0;
        desc_in.a_x_addr = Addr;
        desc_in.way_ind  = Way;
        desc_in.refill   = t.refill;
        r_valid          = t.rv;
        r_in.id          = AxReqId;
        r_in.data        = t.data;
        r_in.resp        = t.resp;
        r_in.last        = t.last;
        wr_ready         = t.wwr;
        desc_ready_in    = t.dri;
        @(negedge clk);
        chk({nm, "_desc_ready"}, desc_ready_out, t.e_dr);
        chk({nm, "_desc_valid"}, desc_valid_out, t.e_dv);
        chk({nm, "_r_ready"},    r_ready,        t.e_rr);
        chk({nm, "_wr_valid"},   wr_valid,       t.e_wv);
        chk({nm, "_resp_err"},   resp_err,       t.e_re);
        chk({nm, "_proto_err"},  proto_err,      t.e_pe);
        if (t.e_wv) begin
            chk({nm, "_wr_ofs"},   wr.blk_ofs, t.e_ofs);
            chk({nm, "_wr_data"},  wr.data,    t.data);
            chk({nm, "_wr_index"}, wr.index,   Idx);
            chk({nm, "_wr_way"},   wr.way_ind, Way);
        end
        if (t.e_dv) begin
            chk({nm, "_desc_addr"}, desc_out.a_x_addr, Addr);
            chk({nm, "_desc_way"},  desc_out.way_ind,  Way);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // A: plain 4-beat refill
        tbl.push_back(acc(1, 0));
        for (int k = 0; k < 4; k++) tbl.push_back(bt(dat(1, k), 2'(k), 2'b00, k == 3, 1, 0));
        tbl.push_back(snd(1, 0));
        tbl.push_back(idl(0));
        // B: no refill, R held valid must be stalled
        tbl.push_back(acc(0, 1));
        tbl.push_back(snd(0, 1));
        tbl.push_back(snd(1, 1));
        tbl.push_back(idl(1));
        // C: way write backpressure 1,0,0,1
        tbl.push_back(acc(1, 0));
        tbl.push_back(bt(dat(3, 0), 2'd0, 2'b00, 0, 1, 0));
        tbl.push_back(bt(dat(3, 1), 2'd1, 2'b00, 0, 0, 0));
        tbl.push_back(bt(dat(3, 1), 2'd1, 2'b00, 0, 0, 0));
        tbl.push_back(bt(dat(3, 1), 2'd1, 2'b00, 0, 1, 0));
        tbl.push_back(bt(dat(3, 2), 2'd2, 2'b00, 0, 1, 0));
        tbl.push_back(bt(dat(3, 3), 2'd3, 2'b00, 1, 1, 0));
        tbl.push_back(snd(1, 0));
        tbl.push_back(idl(0));
        // D: SLVERR on beat 2
        tbl.push_back(acc(1, 0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(bt(dat(4, k), 2'(k), (k == 2) ? 2'b10 : 2'b00, k == 3, 1, 0));
        tbl.push_back(snd(1, 0));
        tbl.push_back(idl(0));
        // E: early rlast on beat 1
        tbl.push_back(acc(1, 0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(bt(dat(5, k), 2'(k), 2'b00, (k == 1) || (k == 3), 1, (k == 1) && ProtoEn));
        tbl.push_back(snd(1, 0));
        tbl.push_back(idl(0));

        desc_valid_in = 1'b0; desc_in = '0; desc_ready_in = 1'b0;
        r_in = '0; r_valid = 1'b1; wr_ready = 1'b1;
        #2;
        chk("reset_desc_ready", desc_ready_out, 1'b1);
        chk("reset_desc_valid", desc_valid_out, 1'b0);
        chk("reset_r_ready",    r_ready,        1'b0);
        chk("reset_wr_valid",   wr_valid,       1'b0);
        chk("reset_resp_err",   resp_err,       1'b0);
        chk("reset_proto_err",  proto_err,      1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("v%0d", i));

        // F: reset in the middle of a burst
        run_vec(acc(1, 0), "f_acc");
        run_vec(bt(dat(6, 0), 2'd0, 2'b00, 0, 1, 0), "f_b0");
        run_vec(bt(dat(6, 1), 2'd1, 2'b00, 0, 1, 0), "f_b1");
        r_valid = 1'b1; r_in.data = dat(6, 2); wr_ready = 1'b1;
        #1;
        chk("f_pre_rst_wr_valid", wr_valid, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("f_rst_desc_ready", desc_ready_out, 1'b1);
        chk("f_rst_desc_valid", desc_valid_out, 1'b0);
        chk("f_rst_r_ready",    r_ready,        1'b0);
        chk("f_rst_wr_valid",   wr_valid,       1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_vec(idl(1), "f_post_idle");
        run_vec(acc(1, 0), "f_acc2");
        for (int k = 0; k < 4; k++)
            run_vec(bt(dat(7, k), 2'(k), 2'b00, k == 3, 1, 0), $sformatf("f_b%0d", k));
        run_vec(snd(1, 0), "f_send");
        run_vec(idl(0), "f_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
